// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: FSM state encoding and CP0 cause codes.
package exc_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHandler = 2'd1,
        StReturn  = 2'd2
    } exc_state_e;

    localparam logic [4:0] ExcInt  = 5'd0;
    localparam logic [4:0] ExcAdel = 5'd4;
    localparam logic [4:0] ExcAdes = 5'd5;
    localparam logic [4:0] ExcRi   = 5'd10;
    localparam logic [4:0] ExcOv   = 5'd12;

    localparam int unsigned HwIntWidth = 6;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for the raw device interrupt lines.
module irq_sync #(
    parameter int unsigned Width = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] async_in,
    output logic [Width-1:0] sync_out
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// Commit-stage exception/interrupt controller driving the CP0 exception write and pipeline flush.
// Build option: EXC_IRQ_SYNC_EN adds a two-flop synchronizer on the interrupt lines.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hwint_in,
    input  logic [31:0] sr,
    input  logic        stage_valid,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic        in_delay_slot,
    input  logic        eret,
    output logic        take,
    output logic [4:0]  ex_out,
    output logic        bd_out,
    output logic [5:0]  hwint_out,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        nested_err
);

    exc_state_e state_q, state_d;
    logic       nested_q, nested_d;
    logic       irq_req;
    logic       take_c;
    logic [5:0] im;
    logic       sr_exl;
    logic       sr_ie;
    logic       unused_sr;

    assign im        = sr[15:10];
    assign sr_exl    = sr[1];
    assign sr_ie     = sr[0];
    assign unused_sr = ^{sr[31:16], sr[9:2]};

`ifdef EXC_IRQ_SYNC_EN
    irq_sync #(
        .Width (HwIntWidth)
    ) u_irq_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (hwint_in),
        .sync_out (hwint_out)
    );
`else
    // Held at zero during reset so CP0 never sees live lines while the block is cleared.
    assign hwint_out = reset ? hwint_in : '0;
`endif

    assign irq_req = (|(hwint_out & im)) && sr_ie && !sr_exl && stage_valid;

    always_comb begin
        state_d  = state_q;
        nested_d = nested_q;
        take_c   = 1'b0;
        case (state_q)
            StIdle: begin
                take_c = reset && ((exc_valid && stage_valid) || irq_req);
                if (take_c) begin
                    state_d = StHandler;
                end
            end
            StHandler: begin
                if (exc_valid && stage_valid) begin
                    nested_d = 1'b1;
                end
                if (eret) begin
                    state_d = StReturn;
                end
            end
            // One dead cycle while CP0 clears EXL, so a stale EXL cannot hide a pending IRQ.
            StReturn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            nested_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            nested_q <= nested_d;
        end
    end

    assign take        = take_c;
    assign flush       = take_c;
    assign ex_out      = (take_c && exc_valid) ? exc_code : ExcInt;
    assign bd_out      = take_c && in_delay_slot;
    assign redirect_pc = HANDLER_PC;
    assign nested_err  = nested_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized self-checking bench for exc_ctrl against a behavioural handler-occupancy model.
module tb_exc_ctrl;

`ifdef EXC_IRQ_SYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  hwint_in = '0;
    logic [31:0] sr = '0;
    logic        stage_valid = 1'b0;
    logic        exc_valid = 1'b0;
    logic [4:0]  exc_code = '0;
    logic        in_delay_slot = 1'b0;
    logic        eret = 1'b0;
    logic        take;
    logic [4:0]  ex_out;
    logic        bd_out;
    logic [5:0]  hwint_out;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        nested_err;

    exc_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .hwint_in      (hwint_in),
        .sr            (sr),
        .stage_valid   (stage_valid),
        .exc_valid     (exc_valid),
        .exc_code      (exc_code),
        .in_delay_slot (in_delay_slot),
        .eret          (eret),
        .take          (take),
        .ex_out        (ex_out),
        .bd_out        (bd_out),
        .hwint_out     (hwint_out),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .nested_err    (nested_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: whether a handler is running, whether we sit in the post-eret gap, and
    // the interrupt lines as delayed by however many clock edges the build inserts.
    bit         m_in_handler = 0;
    bit         m_returning = 0;
    bit         m_nested = 0;
    logic [5:0] m_hist [$];
    logic       last_take;
    logic [4:0] last_ex;
    logic       last_bd;
    logic       last_flush;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_hw();
        if (!reset) return 6'd0;
        if (SyncLat == 0) return hwint_in;
        return m_hist[0];
    endfunction

    task automatic model_reset();
        m_in_handler = 0;
        m_returning = 0;
        m_nested = 0;
        m_hist.delete();
        for (int i = 0; i < SyncLat; i++) m_hist.push_back(6'd0);
    endtask

    // Entered just after a falling edge with inputs applied; leaves just after the next one.
    task automatic step();
        logic [5:0] hw;
        bit irq, idle, e_take;
        #1;
        hw = model_hw();
        irq = (|(hw & sr[15:10])) && sr[0] && !sr[1] && stage_valid;
        idle = !m_in_handler && !m_returning;
        e_take = reset && idle && ((exc_valid && stage_valid) || irq);
        check_eq("take", take, e_take);
        check_eq("flush", flush, e_take);
        check_eq("ex_out", ex_out, (e_take && exc_valid) ? exc_code : 5'd0);
        check_eq("bd_out", bd_out, e_take ? in_delay_slot : 1'b0);
        check_eq("hwint_out", hwint_out, hw);
        check_eq("nested_err", nested_err, m_nested);
        check_eq("redirect_pc", redirect_pc, 32'h0000_4180);
        last_take = take;
        last_ex = ex_out;
        last_bd = bd_out;
        last_flush = flush;
        @(posedge clk);
        if (SyncLat != 0) begin
            void'(m_hist.pop_front());
            m_hist.push_back(hwint_in);
        end
        if (m_returning) begin
            m_returning = 0;
        end else if (m_in_handler) begin
            if (exc_valid && stage_valid) m_nested = 1;
            if (eret) begin
                m_in_handler = 0;
                m_returning = 1;
            end
        end else if (e_take) begin
            m_in_handler = 1;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        exc_valid = 0;
        eret = 0;
        in_delay_slot = 0;
        exc_code = 0;
    endtask

    // Reset pulse with inputs that would otherwise raise take, checked while still low.
    task automatic reset_pulse();
        exc_valid = 1;
        stage_valid = 1;
        exc_code = 5'd5;
        in_delay_slot = 1;
        hwint_in = 6'h3f;
        sr = 32'h0000_fc01;
        #1 reset = 0;
        #1;
        check_eq("rst_take", take, 0);
        check_eq("rst_flush", flush, 0);
        check_eq("rst_bd", bd_out, 0);
        check_eq("rst_ex", ex_out, 0);
        check_eq("rst_hwint", hwint_out, 0);
        check_eq("rst_nested", nested_err, 0);
        model_reset();
        quiet();
        hwint_in = 0;
        sr = 0;
        #1 reset = 1;
    endtask

    initial begin
        int lat;
        model_reset();
        quiet();
        repeat (3) @(negedge clk);
        reset = 1;
        step();
        step();

        // Internal overflow in a delay slot, interrupts disabled.
        exc_valid = 1; exc_code = 5'd12; in_delay_slot = 1; stage_valid = 1; sr = 0;
        step();
        check_eq("ov_take", last_take, 1);
        check_eq("ov_code", last_ex, 5'd12);
        check_eq("ov_bd", last_bd, 1);
        check_eq("ov_flush", last_flush, 1);
        quiet();
        eret = 1; step();
        eret = 0; step();
        step();

        // Pending IRQ blocked by an empty commit stage, then taken once an instruction arrives.
        sr = 32'h0000_0401; hwint_in = 6'b000001; stage_valid = 0;
        repeat (3) begin
            step();
            check_eq("novalid_take", last_take, 0);
        end
        stage_valid = 1;
        step();
        check_eq("irq_take", last_take, 1);
        check_eq("irq_code", last_ex, 5'd0);

        // Nested exception inside the handler, eret, dead cycle, then the still-pending IRQ.
        exc_valid = 1; exc_code = 5'd10;
        step();
        check_eq("nested_take", last_take, 0);
        check_eq("nested_set", nested_err, 1);
        quiet(); eret = 1;
        step();
        eret = 0;
        step();
        check_eq("return_mask", last_take, 0);
        step();
        check_eq("reirq_take", last_take, 1);

        // Abandon the handler via reset.
        reset_pulse();
        step();

        // IRQ latency from a freshly asserted line, then exception priority over it.
        sr = 32'h0000_0401; stage_valid = 1; hwint_in = 6'b000001;
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_take) begin
                lat = i;
                break;
            end
        end
        check_eq("irq_latency", lat, SyncLat);
        eret = 1; step();
        eret = 0; step();
        exc_valid = 1; exc_code = 5'd10; eret = 1;
        step();
        check_eq("prio_code", last_ex, 5'd10);
        quiet();
        eret = 1; step();
        quiet(); step();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            hwint_in = 6'($urandom);
            sr = $urandom;
            sr[1] = ($urandom_range(0, 3) == 0);
            sr[0] = ($urandom_range(0, 3) != 0);
            stage_valid = ($urandom_range(0, 3) != 0);
            exc_valid = ($urandom_range(0, 4) == 0);
            exc_code = 5'($urandom);
            in_delay_slot = 1'($urandom);
            eret = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) reset_pulse();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
